// File: rtl/hazard_scoreboard_if.sv
// Bus between the pipeline and the hazard scoreboard.
// The pipeline (master) drives the ID-stage decode and the EX redirect.
// The scoreboard (slave) returns the stall, flush and forwarding controls.
interface hazard_scoreboard_if #(
  parameter int unsigned RW = 5,
  parameter int unsigned SW = 2,
  parameter int unsigned CW = 32
);
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_wr_en;
  logic [RW-1:0] id_wr_reg;
  logic          id_is_load;
  logic          id_is_md;
  logic          ex_redirect;

  logic          stall;
  logic          bubble_ex;
  logic          hold_ex;
  logic          bubble_mem;
  logic          flush_if;
  logic [SW-1:0] fwd_a;
  logic [SW-1:0] fwd_b;
  logic          wb_byp_a;
  logic          wb_byp_b;
  logic          md_busy;
  logic [CW-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_reg,
           id_is_load, id_is_md, ex_redirect,
    input  stall, bubble_ex, hold_ex, bubble_mem, flush_if, fwd_a, fwd_b,
           wb_byp_a, wb_byp_b, md_busy, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_reg,
           id_is_load, id_is_md, ex_redirect,
    output stall, bubble_ex, hold_ex, bubble_mem, flush_if, fwd_a, fwd_b,
           wb_byp_a, wb_byp_b, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and flush controller for the pipelined MIPS core.
// Every in-flight instruction from EX (stage 0) to WB (stage NSTAGE-1) is
// tracked. Forward selects, load-use stalls, redirect flushes, WB
// write-through bypasses, multi-cycle EX holds and a saturating stall
// counter are all derived from that record.
module hazard_scoreboard #(
  parameter int unsigned NSTAGE     = 3,
  parameter int unsigned RW         = 5,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned MDLAT      = 4,
  parameter int unsigned CW         = 32,
  parameter int unsigned SW         = $clog2(NSTAGE)
) (
  input logic               clk,
  input logic               reset,
  hazard_scoreboard_if.slave bus
);

  localparam int unsigned MW = (MDLAT > 1) ? $clog2(MDLAT) : 1;
  localparam logic [MW-1:0] MD_INIT = MW'(MDLAT - 1);

  typedef struct packed {
    logic          v;
    logic          we;
    logic [RW-1:0] rd;
    logic          ld;
    logic          md;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          urs;
    logic          urt;
  } entry_t;

  entry_t        stage_q [NSTAGE];
  entry_t        stage_d [NSTAGE];
  entry_t        id_entry;
  logic [MW-1:0] md_cnt_q, md_cnt_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  logic          md_busy_int;
  logic          load_use;
  logic          stall_int, bubble_ex_int, hold_ex_int, bubble_mem_int, flush_if_int;
  logic [SW-1:0] fwd_a_int, fwd_b_int;
  logic          wb_byp_a_int, wb_byp_b_int;

  function automatic logic writer(entry_t e);
    return e.v & e.we & (e.rd != '0);
  endfunction

  // Package the ID-stage decode into a tracking entry.
  always_comb begin
    id_entry     = '0;
    id_entry.v   = bus.id_valid;
    id_entry.we  = bus.id_wr_en;
    id_entry.rd  = bus.id_wr_reg;
    id_entry.ld  = bus.id_is_load;
    id_entry.md  = bus.id_is_md;
    id_entry.rs  = bus.id_rs;
    id_entry.rt  = bus.id_rt;
    id_entry.urs = bus.id_use_rs;
    id_entry.urt = bus.id_use_rt;
  end

  // Hazard detection and prioritised pipeline control.
  always_comb begin
    md_busy_int = stage_q[0].v & stage_q[0].md & (md_cnt_q != '0);

    // A load is unsafe if it will still sit below LOAD_STAGE once the ID
    // instruction reaches EX.
    load_use = 1'b0;
    for (int unsigned j = 0; (j + 1 < LOAD_STAGE) && (j < NSTAGE); j++) begin
      if (stage_q[j].ld && writer(stage_q[j]) &&
          ((bus.id_use_rs && (stage_q[j].rd == bus.id_rs)) ||
           (bus.id_use_rt && (stage_q[j].rd == bus.id_rt)))) begin
        load_use = 1'b1;
      end
    end
    load_use = load_use & bus.id_valid;

    stall_int      = 1'b0;
    bubble_ex_int  = 1'b0;
    hold_ex_int    = 1'b0;
    bubble_mem_int = 1'b0;
    flush_if_int   = 1'b0;
    if (md_busy_int) begin
      stall_int      = 1'b1;
      hold_ex_int    = 1'b1;
      bubble_mem_int = 1'b1;
    end else if (bus.ex_redirect) begin
      flush_if_int  = 1'b1;
      bubble_ex_int = 1'b1;
    end else if (load_use) begin
      stall_int     = 1'b1;
      bubble_ex_int = 1'b1;
    end
  end

  // Forward selects for the EX instruction; descending scan keeps the youngest.
  always_comb begin
    fwd_a_int = '0;
    fwd_b_int = '0;
    for (int k = NSTAGE - 1; k >= 1; k--) begin
      if (writer(stage_q[k]) && stage_q[0].urs && (stage_q[k].rd == stage_q[0].rs)) begin
        fwd_a_int = SW'(k);
      end
      if (writer(stage_q[k]) && stage_q[0].urt && (stage_q[k].rd == stage_q[0].rt)) begin
        fwd_b_int = SW'(k);
      end
    end
    wb_byp_a_int = bus.id_use_rs & writer(stage_q[NSTAGE-1]) &
                   (stage_q[NSTAGE-1].rd == bus.id_rs);
    wb_byp_b_int = bus.id_use_rt & writer(stage_q[NSTAGE-1]) &
                   (stage_q[NSTAGE-1].rd == bus.id_rt);
  end

  // Next state: stage shift, multi-cycle countdown and stall counter.
  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      stage_d[k] = stage_q[k];
    end
    md_cnt_d    = md_cnt_q;
    stall_cnt_d = stall_cnt_q;

    if (md_busy_int) begin
      // EX holds the multi-cycle op; MEM receives a bubble.
      stage_d[1] = '0;
    end else begin
      stage_d[0] = (bubble_ex_int || !bus.id_valid) ? '0 : id_entry;
      stage_d[1] = stage_q[0];
    end
    for (int k = 2; k < NSTAGE; k++) begin
      stage_d[k] = stage_q[k-1];
    end

    if (!md_busy_int && !bubble_ex_int && bus.id_valid && bus.id_is_md) begin
      md_cnt_d = MD_INIT;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MW'(1);
    end

    if (stall_int && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NSTAGE; k++) begin
        stage_q[k] <= '0;
      end
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NSTAGE; k++) begin
        stage_q[k] <= stage_d[k];
      end
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are forced low while reset is held.
  always_comb begin
    bus.stall      = reset & stall_int;
    bus.bubble_ex  = reset & bubble_ex_int;
    bus.hold_ex    = reset & hold_ex_int;
    bus.bubble_mem = reset & bubble_mem_int;
    bus.flush_if   = reset & flush_if_int;
    bus.md_busy    = reset & md_busy_int;
    bus.wb_byp_a   = reset & wb_byp_a_int;
    bus.wb_byp_b   = reset & wb_byp_b_int;
    bus.fwd_a      = reset ? fwd_a_int : '0;
    bus.fwd_b      = reset ? fwd_b_int : '0;
    bus.stall_cnt  = reset ? stall_cnt_q : '0;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Stimulus pushes expected outputs
// into a queue; a negedge monitor pops and compares them. A second instance
// with CW=2 and MDLAT=1 shares the inputs to cover saturation and the
// single-cycle multi-cycle case.
module tb_hazard_scoreboard;

  logic clk;
  logic reset;

  hazard_scoreboard_if #(.RW(5), .SW(2), .CW(32)) hb ();
  hazard_scoreboard_if #(.RW(5), .SW(2), .CW(2))  hb2 ();

  hazard_scoreboard #(
    .NSTAGE(3), .RW(5), .LOAD_STAGE(2), .MDLAT(4), .CW(32), .SW(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (hb)
  );

  hazard_scoreboard #(
    .NSTAGE(3), .RW(5), .LOAD_STAGE(2), .MDLAT(1), .CW(2), .SW(2)
  ) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (hb2)
  );

  assign hb2.id_valid    = hb.id_valid;
  assign hb2.id_rs       = hb.id_rs;
  assign hb2.id_rt       = hb.id_rt;
  assign hb2.id_use_rs   = hb.id_use_rs;
  assign hb2.id_use_rt   = hb.id_use_rt;
  assign hb2.id_wr_en    = hb.id_wr_en;
  assign hb2.id_wr_reg   = hb.id_wr_reg;
  assign hb2.id_is_load  = hb.id_is_load;
  assign hb2.id_is_md    = hb.id_is_md;
  assign hb2.ex_redirect = hb.ex_redirect;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: stall,bex,hold,bmem,flush,busy,bypa,bypb,fwd_a,fwd_b,cnt
  typedef struct {
    string       name;
    int          inst;
    logic [43:0] mask;
    logic [43:0] val;
  } exp_t;

  localparam logic [43:0] M_CTL = {6'h3f, 38'h0};
  localparam logic [43:0] M_BYP = {6'h0, 2'h3, 36'h0};
  localparam logic [43:0] M_FWD = {8'h0, 4'hf, 32'h0};
  localparam logic [43:0] M_CNT = {12'h0, 32'hffff_ffff};

  exp_t exp_q[$];
  exp_t mon_e;
  logic [43:0] act;
  int checks = 0;
  int passed = 0;

  function automatic logic [43:0] vec1();
    return {hb.stall, hb.bubble_ex, hb.hold_ex, hb.bubble_mem, hb.flush_if, hb.md_busy,
            hb.wb_byp_a, hb.wb_byp_b, hb.fwd_a, hb.fwd_b, hb.stall_cnt};
  endfunction

  function automatic logic [43:0] vec2();
    return {hb2.stall, hb2.bubble_ex, hb2.hold_ex, hb2.bubble_mem, hb2.flush_if,
            hb2.md_busy, hb2.wb_byp_a, hb2.wb_byp_b, hb2.fwd_a, hb2.fwd_b,
            30'h0, hb2.stall_cnt};
  endfunction

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      act = (mon_e.inst == 0) ? vec1() : vec2();
      checks++;
      if ((act & mon_e.mask) === (mon_e.val & mon_e.mask)) begin
        passed++;
      end else begin
        $display("FAIL %s (dut%0d): got %h, want %h (mask %h)", mon_e.name, mon_e.inst,
                 act & mon_e.mask, mon_e.val & mon_e.mask, mon_e.mask);
      end
    end
  end

  task automatic push(input string name, input int inst, input logic [43:0] mask,
                      input logic [43:0] val);
    exp_t e;
    e.name = name;
    e.inst = inst;
    e.mask = mask;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic ctl(input string name, input int inst, input logic s, input logic be,
                     input logic he, input logic bm, input logic fl, input logic busy);
    push(name, inst, M_CTL, {s, be, he, bm, fl, busy, 38'h0});
  endtask

  task automatic fwd(input string name, input int inst, input logic [1:0] a,
                     input logic [1:0] b);
    push(name, inst, M_FWD, {8'h0, a, b, 32'h0});
  endtask

  task automatic byp(input string name, input int inst, input logic a, input logic b);
    push(name, inst, M_BYP, {6'h0, a, b, 36'h0});
  endtask

  task automatic cnt(input string name, input int inst, input logic [31:0] c);
    push(name, inst, M_CNT, {12'h0, c});
  endtask

  task automatic all0(input string name, input int inst);
    push(name, inst, '1, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic we,
                        input logic [4:0] wr, input logic ld, input logic md);
    hb.id_valid   = v;
    hb.id_rs      = rs;
    hb.id_rt      = rt;
    hb.id_use_rs  = urs;
    hb.id_use_rt  = urt;
    hb.id_wr_en   = we;
    hb.id_wr_reg  = wr;
    hb.id_is_load = ld;
    hb.id_is_md   = md;
  endtask

  task automatic id_idle();
    id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    hb.ex_redirect = 1'b0;
    id_idle();
    step();
    all0("reset_low", 0);
    all0("reset_low", 1);
    step();
    reset = 1'b1;

    // Back-to-back ALU forwarding.
    id_set(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0);          // add r3,r1,r2
    ctl("alu_first", 0, 0, 0, 0, 0, 0, 0);
    step();
    id_set(1, 5'd3, 5'd1, 1, 1, 1, 5'd4, 0, 0);          // sub r4,r3,r1
    ctl("alu_dep_id", 0, 0, 0, 0, 0, 0, 0);
    step();
    id_set(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0);          // add r3,r1,r2
    fwd("fwd_from_mem", 0, 2'd1, 2'd0);
    step();
    id_set(1, 5'd5, 5'd6, 1, 1, 1, 5'd8, 0, 0);          // or r8,r5,r6
    step();
    id_set(1, 5'd3, 5'd8, 1, 1, 1, 5'd4, 0, 0);          // sub r4,r3,r8
    step();
    id_idle();
    fwd("fwd_wb_and_mem", 0, 2'd2, 2'd1);
    ctl("fwd_no_stall", 0, 0, 0, 0, 0, 0, 0);

    // Load-use: one stall, then forward from WB.
    step();
    id_set(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1, 0);          // lw r5
    step();
    id_set(1, 5'd5, 5'd5, 1, 1, 1, 5'd6, 0, 0);          // add r6,r5,r5
    ctl("load_use_stall", 0, 1, 1, 0, 0, 0, 0);
    ctl("load_use_stall", 1, 1, 1, 0, 0, 0, 0);
    step();
    ctl("load_use_release", 0, 0, 0, 0, 0, 0, 0);
    cnt("cnt_after_load_use", 0, 32'd1);
    step();
    id_set(1, 5'd1, 5'd0, 1, 0, 1, 5'd0, 1, 0);          // lw r0
    fwd("fwd_load_from_wb", 0, 2'd2, 2'd2);

    // Register 0 neither stalls nor forwards.
    step();
    id_set(1, 5'd0, 5'd0, 1, 1, 1, 5'd10, 0, 0);         // add r10,r0,r0
    ctl("r0_no_stall", 0, 0, 0, 0, 0, 0, 0);
    step();
    id_idle();
    fwd("r0_no_fwd", 0, 2'd0, 2'd0);

    // Multi-cycle op: three busy cycles, redirect ignored while busy.
    step();
    id_set(1, 5'd1, 5'd2, 1, 1, 1, 5'd11, 0, 1);         // mul r11
    step();
    id_set(1, 5'd11, 5'd0, 1, 0, 1, 5'd12, 0, 0);        // add r12,r11
    ctl("md_busy_1", 0, 1, 0, 1, 1, 0, 1);
    ctl("md_lat1_no_busy", 1, 0, 0, 0, 0, 0, 0);
    step();
    hb.ex_redirect = 1'b1;
    ctl("md_busy_2_redirect", 0, 1, 0, 1, 1, 0, 1);
    step();
    hb.ex_redirect = 1'b0;
    ctl("md_busy_3", 0, 1, 0, 1, 1, 0, 1);
    step();
    ctl("md_done", 0, 0, 0, 0, 0, 0, 0);
    cnt("cnt_after_md", 0, 32'd4);
    step();
    id_set(1, 5'd1, 5'd0, 1, 0, 1, 5'd7, 1, 0);          // lw r7
    fwd("md_in_mem", 0, 2'd1, 2'd0);

    // Redirect beats a load-use hazard.
    step();
    id_set(1, 5'd7, 5'd7, 1, 1, 1, 5'd13, 0, 0);         // add r13,r7,r7
    hb.ex_redirect = 1'b1;
    ctl("redirect_over_load", 0, 0, 1, 0, 0, 1, 0);
    step();
    hb.ex_redirect = 1'b0;
    id_set(1, 5'd1, 5'd2, 1, 1, 1, 5'd9, 0, 0);          // add r9
    ctl("after_redirect", 0, 0, 0, 0, 0, 0, 0);
    cnt("cnt_after_redirect", 0, 32'd4);

    // WB write-through bypass.
    step();
    id_idle();
    step();
    step();
    id_set(1, 5'd9, 5'd9, 1, 0, 1, 5'd14, 0, 0);         // reads r9 via rs only
    byp("wb_bypass", 0, 1'b1, 1'b0);

    // Reset during a multi-cycle op.
    step();
    id_set(1, 5'd1, 5'd2, 1, 1, 1, 5'd15, 0, 1);         // mul r15
    step();
    id_idle();
    reset = 1'b0;
    all0("reset_mid_md", 0);
    all0("reset_mid_md", 1);
    step();
    reset = 1'b1;
    all0("after_reset", 0);
    all0("after_reset", 1);

    // Repeated load-use stalls; the CW=2 instance saturates at 3.
    for (int i = 0; i < 4; i++) begin
      step();
      id_set(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1, 0);        // lw r5
      step();
      id_set(1, 5'd5, 5'd5, 1, 1, 1, 5'd6, 0, 0);        // add r6,r5,r5
      ctl("sat_stall", 0, 1, 1, 0, 0, 0, 0);
      step();
      cnt("sat_cnt_wide", 0, 32'(i + 1));
      cnt("sat_cnt_narrow", 1, (i < 3) ? 32'(i + 1) : 32'd3);
    end
    step();
    id_idle();
    cnt("cnt_four", 0, 32'd4);
    cnt("cnt_saturated", 1, 32'd3);

    step();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
